// File: rtl/uart_tx_frame.sv
// Multi-byte UART transmitter: serialises a NUM_BYTES word as back-to-back
// 8-bit characters with optional parity and 1/2 stop bits, own baud divider.
// Ports: clk, rst_n (async low), baud_set[2:0], data[8*NUM_BYTES-1:0],
//        trans_go (start request) -> data_tx (line), busy, tx_done (pulse).
module uart_tx_frame #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int NUM_BYTES  = 4,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             baud_set,
  input  logic [8*NUM_BYTES-1:0] data,
  input  logic                   trans_go,
  output logic                   data_tx,
  output logic                   busy,
  output logic                   tx_done
);

  localparam int DW = 8 * NUM_BYTES;
  localparam int D0 = CLK_FREQ / 9600;
  localparam int D1 = CLK_FREQ / 19200;
  localparam int D2 = CLK_FREQ / 38400;
  localparam int D3 = CLK_FREQ / 57600;
  localparam int D4 = CLK_FREQ / 115200;
  localparam int CW = $clog2(D0 + 1);
  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [BW-1:0] LAST_IDX = BW'(NUM_BYTES - 1);
  localparam logic [2:0]    LAST_STP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   word_q, word_d;
  logic [2:0]      baud_q, baud_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [CW-1:0]   div_max;
  logic            bit_end;
  logic [BW-1:0]   sel;
  logic [7:0]      cur_byte;
  logic            par_bit;

  always_comb begin
    div_max = CW'(D4 - 1);
    case (baud_q)
      3'd0:    div_max = CW'(D0 - 1);
      3'd1:    div_max = CW'(D1 - 1);
      3'd2:    div_max = CW'(D2 - 1);
      3'd3:    div_max = CW'(D3 - 1);
      default: div_max = CW'(D4 - 1);
    endcase
  end

  assign bit_end = (cnt_q == div_max);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    word_d  = word_q;
    baud_d  = baud_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (trans_go) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          idx_d   = '0;
          word_d  = data;
          baud_d  = baud_set;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == LAST_STP) begin
            bit_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              // next character follows with no idle gap
              state_d = S_START;
              idx_d   = idx_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // line value is derived from next-state so the output flop
  // changes exactly on bit boundaries
  assign sel      = (MSB_FIRST != 0) ? (LAST_IDX - idx_d) : idx_d;
  assign cur_byte = word_d[sel*8 +: 8];
  assign par_bit  = (^cur_byte) ^ (PARITY_ODD != 0);

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    unique case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      S_PAR:   tx_d = par_bit;
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_tx = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: framing, byte order, parity, divider
// values, back-to-back, ignored mid-frame requests, async reset.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  bs0, bs1, bs2;
  logic [31:0] d0, d2;
  logic [15:0] d1;
  logic        go0, go1, go2;
  logic        tx0, tx1, tx2;
  logic        by0, by1, by2;
  logic        dn0, dn1, dn2;

  uart_tx_frame #(.CLK_FREQ(5_000_000)) u_main (
    .clk(clk), .rst_n(rst_n), .baud_set(bs0), .data(d0),
    .trans_go(go0), .data_tx(tx0), .busy(by0), .tx_done(dn0));

  uart_tx_frame #(
    .CLK_FREQ(5_000_000), .NUM_BYTES(2), .MSB_FIRST(0),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) u_par (
    .clk(clk), .rst_n(rst_n), .baud_set(bs1), .data(d1),
    .trans_go(go1), .data_tx(tx1), .busy(by1), .tx_done(dn1));

  uart_tx_frame u_def (
    .clk(clk), .rst_n(rst_n), .baud_set(bs2), .data(d2),
    .trans_go(go2), .data_tx(tx2), .busy(by2), .tx_done(dn2));

  int checks   = 0;
  int failures = 0;
  logic rec[$];

  typedef struct {
    logic [31:0] data;
    logic [2:0]  baud;
    logic [31:0] exp;
    int          len;
  } vec_t;

  typedef struct {
    logic [2:0] baud;
    int         len;
  } bvec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic tx_of(input int id);
    case (id)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic busy_of(input int id);
    case (id)
      0:       return by0;
      1:       return by1;
      default: return by2;
    endcase
  endfunction

  function automatic logic done_of(input int id);
    case (id)
      0:       return dn0;
      1:       return dn1;
      default: return dn2;
    endcase
  endfunction

  // Called on the negedge of the first busy cycle; records the line
  // once per cycle while busy (bounded by max_cyc).
  task automatic capture(input int id, input int max_cyc,
                         input int glitch_at, input logic b2b,
                         input logic [31:0] b2b_data,
                         output int len, output logic done_ok);
    rec.delete();
    len = 0;
    while (busy_of(id) && len < max_cyc) begin
      rec.push_back(tx_of(id));
      len++;
      if (id == 0) begin
        if (len == glitch_at) begin
          go0 = 1'b1;
          d0  = 32'hffff_ffff;
        end else begin
          go0 = 1'b0;
        end
      end
      @(negedge clk);
    end
    if (id == 0) go0 = 1'b0;
    done_ok = done_of(id) && !busy_of(id);
    if (b2b) begin
      go0 = 1'b1;
      d0  = b2b_data;
    end
  endtask

  task automatic check_chars(input string name, input logic [31:0] exp,
                             input int nb, input int nchars,
                             input int pe, input int sb, input int l);
    int cl;
    cl = 10 + pe + sb - 1;
    for (int k = 0; k < nchars; k++) begin
      logic [7:0]  b;
      logic [11:0] ev;
      logic [11:0] ov;
      int          bad;
      b   = exp[8*(nb-1-k) +: 8];
      ev  = '1;
      ov  = '1;
      bad = 0;
      ev[0] = 1'b0;
      for (int j = 0; j < 8; j++) ev[1+j] = b[j];
      if (pe != 0) ev[9] = ^b;
      for (int i = 0; i < cl; i++) begin
        int base;
        base  = (k * cl + i) * l;
        ov[i] = rec[base + l/2];
        for (int s = 0; s < l; s++)
          if (rec[base + s] !== ov[i]) bad++;
      end
      chk($sformatf("%s char%0d bits", name, k), 64'(ov), 64'(ev));
      chk($sformatf("%s char%0d stable", name, k), 64'(bad), 64'd0);
    end
  endtask

  task automatic start0(input logic [31:0] d, input logic [2:0] b);
    @(negedge clk);
    d0  = d;
    bs0 = b;
    go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  tbl[4];
    bvec_t btbl[8];
    int    len;
    logic  dok;
    int    bad;
    int    cnt;

    tbl[0] = '{32'h2458_9b3f, 3'd4, 32'h2458_9b3f, 43};
    tbl[1] = '{32'ha5c3_0f81, 3'd3, 32'ha5c3_0f81, 86};
    tbl[2] = '{32'h00ff_7e01, 3'd1, 32'h00ff_7e01, 260};
    tbl[3] = '{32'hdead_beef, 3'd7, 32'hdead_beef, 43};

    btbl[0] = '{3'd0, 5208};
    btbl[1] = '{3'd1, 2604};
    btbl[2] = '{3'd2, 1302};
    btbl[3] = '{3'd3, 868};
    btbl[4] = '{3'd4, 434};
    btbl[5] = '{3'd5, 434};
    btbl[6] = '{3'd6, 434};
    btbl[7] = '{3'd7, 434};

    rst_n = 1'b0;
    go0 = 0; go1 = 0; go2 = 0;
    bs0 = 0; bs1 = 0; bs2 = 0;
    d0 = 0; d1 = 0; d2 = 0;

    // reset and quiet idle
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(tx0 && tx1 && tx2) || by0 || by1 || by2 || dn0 || dn1 || dn2)
        bad++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(tx0 && tx1 && tx2) || by0 || by1 || by2 || dn0 || dn1 || dn2)
        bad++;
    end
    chk("reset idle", 64'(bad), 64'd0);
    chk("reset line", 64'({tx0, by0, dn0}), 64'(3'b100));

    // table of single frames on the main instance
    foreach (tbl[v]) begin
      start0(tbl[v].data, tbl[v].baud);
      chk($sformatf("v%0d start", v), 64'({by0, tx0}), 64'(2'b10));
      capture(0, 40 * tbl[v].len + 10, -1, 1'b0, 32'h0, len, dok);
      chk($sformatf("v%0d busy len", v), 64'(len), 64'(40 * tbl[v].len));
      chk($sformatf("v%0d done", v), 64'(dok), 64'd1);
      check_chars($sformatf("v%0d", v), tbl[v].exp, 4, 4, 0, 1, tbl[v].len);
      @(negedge clk);
      chk($sformatf("v%0d done pulse", v), 64'(dn0), 64'd0);
    end

    // back-to-back: request in the tx_done cycle
    start0(32'h2458_9b3f, 3'd4);
    capture(0, 1730, -1, 1'b1, 32'h1234_5678, len, dok);
    chk("b2b first done", 64'(dok), 64'd1);
    check_chars("b2b first", 32'h2458_9b3f, 4, 4, 0, 1, 43);
    @(negedge clk);
    go0 = 1'b0;
    chk("b2b no gap", 64'({by0, tx0}), 64'(2'b10));
    capture(0, 1730, -1, 1'b0, 32'h0, len, dok);
    chk("b2b second len", 64'(len), 64'd1720);
    chk("b2b second done", 64'(dok), 64'd1);
    check_chars("b2b second", 32'h1234_5678, 4, 4, 0, 1, 43);

    // mid-frame request and data change are ignored
    start0(32'h2458_9b3f, 3'd4);
    capture(0, 1730, 300, 1'b0, 32'h0, len, dok);
    chk("glitch len", 64'(len), 64'd1720);
    chk("glitch done", 64'(dok), 64'd1);
    check_chars("glitch", 32'h2458_9b3f, 4, 4, 0, 1, 43);
    bad = 0;
    repeat (130) begin
      @(negedge clk);
      if (dn0 || by0 || !tx0) bad++;
    end
    chk("glitch no requeue", 64'(bad), 64'd0);

    // parity, two stop bits, LSB byte first
    @(negedge clk);
    d1  = 16'h9b3f;
    bs1 = 3'd4;
    go1 = 1'b1;
    @(negedge clk);
    go1 = 1'b0;
    capture(1, 1040, -1, 1'b0, 32'h0, len, dok);
    chk("par len", 64'(len), 64'd1032);
    chk("par done", 64'(dok), 64'd1);
    chk("par bit 0x3f", 64'(rec[9*43 + 21]), 64'd0);
    chk("par bit 0x9b", 64'(rec[(12+9)*43 + 21]), 64'd1);
    check_chars("par", 32'h0000_3f9b, 2, 2, 1, 2, 43);

    // reset in the middle of byte 2 at 9600 baud
    start0(32'h2458_9b3f, 3'd0);
    capture(0, 10500, -1, 1'b0, 32'h0, len, dok);
    chk("rst partial len", 64'(len), 64'd10500);
    check_chars("rst partial", 32'h2458_9b3f, 4, 2, 0, 1, 520);
    chk("rst pre line", 64'({by0, tx0}), 64'(2'b10));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async", 64'({tx0, by0, dn0}), 64'(3'b100));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst released idle", 64'({tx0, by0, dn0}), 64'(3'b100));
    start0(32'h2458_9b3f, 3'd4);
    capture(0, 1730, -1, 1'b0, 32'h0, len, dok);
    chk("rst fresh len", 64'(len), 64'd1720);
    chk("rst fresh done", 64'(dok), 64'd1);
    check_chars("rst fresh", 32'h2458_9b3f, 4, 4, 0, 1, 43);

    // divider values at 50 MHz, measured on the start bit
    foreach (btbl[v]) begin
      @(negedge clk);
      d2  = 32'hff00_0000;
      bs2 = btbl[v].baud;
      go2 = 1'b1;
      @(negedge clk);
      go2 = 1'b0;
      cnt = 0;
      while (tx2 == 1'b0 && cnt < 6000) begin
        cnt++;
        @(negedge clk);
      end
      chk($sformatf("div baud%0d", btbl[v].baud), 64'(cnt),
          64'(btbl[v].len));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
